// File: rtl/decimator_pkg.sv
// Shared constants and helpers for the power-of-two decimator.
package decimator_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

  // The sum of up to 2^log2_max_factor samples needs log2_max_factor extra bits.
  function automatic int acc_width(input int word_length, input int log2_max_factor);
    return word_length + log2_max_factor;
  endfunction

  function automatic int clamp_sel(input int sel, input int max_sel);
    return (sel > max_sel) ? max_sel : sel;
  endfunction

endpackage

// File: rtl/decim_group_ctrl.sv
// Group bookkeeping: sample counter, per-group config latch and factor clamp.
module decim_group_ctrl
  import decimator_pkg::*;
#(
  parameter int log2_max_factor = 4,
  parameter int sel_width       = $clog2(log2_max_factor + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 accept,
  input  logic [sel_width-1:0] factor_sel,
  input  logic                 mode,
  output logic                 first_sample,
  output logic                 last_sample,
  output logic [sel_width-1:0] eff_shift,
  output logic                 eff_mode
);

  logic [log2_max_factor-1:0] r_count;
  logic [sel_width-1:0]       r_shift;
  logic                       r_mode;
  logic [sel_width-1:0]       w_sel_clamped;
  logic [log2_max_factor:0]   w_one;

  assign w_sel_clamped = sel_width'(clamp_sel(int'(factor_sel), log2_max_factor));
  assign w_one         = (log2_max_factor + 1)'(1);

  // Live inputs steer the first sample of a group; the latched copy steers the rest.
  assign first_sample = (r_count == '0);
  assign eff_shift    = first_sample ? w_sel_clamped : r_shift;
  assign eff_mode     = first_sample ? mode : r_mode;
  assign last_sample  = (r_count == log2_max_factor'((w_one << eff_shift) - w_one));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_shift <= '0;
      r_mode  <= MODE_PICK;
    end else if (accept) begin
      if (first_sample) begin
        r_shift <= w_sel_clamped;
        r_mode  <= mode;
      end
      r_count <= last_sample ? '0 : r_count + log2_max_factor'(1);
    end
  end

endmodule

// File: rtl/decimator_n.sv
// Run-time selectable 2^k decimator with pick-last and block-average modes.
module decimator_n
  import decimator_pkg::*;
#(
  parameter int word_length     = 8,
  parameter int log2_max_factor = 4,
  parameter int sel_width       = $clog2(log2_max_factor + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [word_length-1:0] data_in,
  input  logic                   in_valid,
  input  logic                   hold,
  input  logic [sel_width-1:0]   factor_sel,
  input  logic                   mode,
  output logic [word_length-1:0] data_out,
  output logic                   out_valid
);

  localparam int ACC_W = acc_width(word_length, log2_max_factor);

  logic                 w_accept;
  logic                 w_first;
  logic                 w_last;
  logic [sel_width-1:0] w_eff_shift;
  logic                 w_eff_mode;
  logic [ACC_W-1:0]     w_sum;
  logic [ACC_W-1:0]     r_acc;

  assign w_accept = in_valid & ~hold;

  decim_group_ctrl #(
    .log2_max_factor(log2_max_factor),
    .sel_width      (sel_width)
  ) u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .accept      (w_accept),
    .factor_sel  (factor_sel),
    .mode        (mode),
    .first_sample(w_first),
    .last_sample (w_last),
    .eff_shift   (w_eff_shift),
    .eff_mode    (w_eff_mode)
  );

  // Running group sum including the current sample; a new group restarts from it.
  assign w_sum = w_first ? ACC_W'(data_in) : r_acc + ACC_W'(data_in);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_accept & w_last;
      if (w_accept) begin
        r_acc <= w_sum;
        if (w_last) begin
          data_out <= (w_eff_mode == MODE_AVG) ? word_length'(w_sum >> w_eff_shift) : data_in;
        end
      end
    end
  end

endmodule

// File: doc/decimator_n.md
Name: decimator_n

Overview:
- Parametrised successor to the single-rate decimator in the DSP chapter.
- Reduces a sample stream by a run-time selectable factor M = 2^factor_sel, with M ranging from 1 to 2^log2_max_factor.
- Two modes:
  - pick: output the last sample of each group of M.
  - average: output the sum of the M samples, right-shifted by factor_sel.
- Sits between a sample source (ADC / upstream filter) and downstream rate-reduced DSP stages.
- Adds an input qualifier and an output valid strobe, which the fixed-rate predecessor does not have.

Parameters:
- word_length, 8: sample width (unsigned).
- log2_max_factor, 4: maximum decimation exponent; M max = 16.
- sel_width, $clog2(log2_max_factor+1) (= 3): width of factor_sel.

Ports:
- clock  in  1  system clock; all state updates on its positive edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  word_length  input sample.
- in_valid  in  1  data_in carries a sample this cycle.
- hold  in  1  active high; freezes the block, so samples are ignored.
- factor_sel  in  sel_width  decimation exponent; values above log2_max_factor clamp to log2_max_factor.
- mode  in  1  0 = pick, 1 = average.
- data_out  out  word_length  decimated sample, registered.
- out_valid  out  1  one-cycle strobe marking a new data_out.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - data_out=0, out_valid=0, group count=0, accumulator=0, latched cfg (shift=0, mode=pick).
  - Reset overrides every other input, including hold.
- Accept: a sample is accepted when in_valid=1, hold=0 and reset=0.
- Config latch:
  - When an accepted sample has count==0, factor_sel (clamped) and mode are used directly and latched for the rest of the group.
  - For count>0 the latched values are used.
  - Changes to factor_sel or mode mid-group therefore take effect at the next group.
- Counter: count runs 0..M-1 on accepted samples and wraps to 0 after the sample where count==M-1. That sample is the group's last sample.
- Accumulator:
  - Width word_length+log2_max_factor, so no overflow is possible.
  - The first sample of a group loads acc=data_in; later samples add, acc=acc+data_in.
- Output on the last sample:
  - Pick mode: data_out <= data_in.
  - Average mode: data_out <= (acc+data_in)>>shift, truncated toward zero.
  - out_valid <= 1 on the next edge, i.e. 1-cycle latency after the last sample.
- out_valid is 0 on every other cycle. data_out retains its value between strobes.
- M=1 (factor_sel=0): every accepted sample produces an output. Average mode returns the sample unchanged.
- hold=1:
  - count, accumulator and latched cfg are frozen.
  - data_out holds and out_valid=0.
  - Resume continues the same group.
- in_valid=0 with hold=0: same frozen state; a gap in the stream does not break the group.
- Reset mid-group: the partial group is discarded. The next accepted sample starts a fresh group with freshly latched cfg.
- No back-pressure: the downstream must accept every out_valid strobe.

Decomposition:
- Package decimator_pkg holds:
  - MODE_PICK=1'b0 and MODE_AVG=1'b1.
  - An acc_width(word_length, log2_max_factor) function.
  - The sel clamp function.
- One natural sub-module, decim_group_ctrl:
  - Contains the count register, cfg latch and clamp.
  - Outputs first_sample, last_sample, eff_shift and eff_mode.
  - The top level keeps the accumulator and output registers.

Test Plan:
1. Pick, factor_sel=2, in_valid=1 continuous, data_in ramp 1,2,3,...,8 → out_valid pulses 1 cycle after samples 4 and 8; data_out=4 then 8.
2. Average, factor_sel=2, ramp 1..8 → data_out=2 (10>>2) then 6 (26>>2). Then all-255 input with factor_sel=4 → data_out=255 (4080>>4), no overflow.
3. Hold/valid gaps, pick M=4, ramp 1..8 with hold=1 during sample 3 and in_valid=0 for 2 cycles after sample 5:
   - Samples 3 and the gap cycles are not counted.
   - First output = 5 (accepted 1,2,4,5).
   - data_out stable and out_valid=0 throughout the hold.
4. Config change mid-group: start M=4 average, switch to factor_sel=0 pick after 2 samples → current group completes as M=4 average; subsequent samples each output unchanged at M=1. factor_sel=7 behaves as 4 (M=16).
5. Reset mid-group: M=4, 2 samples accepted, reset=1 for 1 cycle → data_out=0, out_valid=0; next output only after 4 new samples (e.g. 10,20,30,40 in pick → 40).
6. M=1 average with random data → data_out equals data_in delayed by one cycle and out_valid mirrors accepted in_valid delayed by one cycle.
